// File: rtl/piece_queue.sv
// piece_queue: filters generator pieces (drops code 7 and one immediate repeat),
// buffers accepted pieces in a small FIFO and issues the oldest piece on request.
module piece_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       gen_shape,
  input  logic [1:0]       gen_rot,
  input  logic             spawn_req,
  output logic             spawn_valid,
  output logic [2:0]       spawn_shape,
  output logic [1:0]       spawn_rot,
  output logic [2:0]       next_shape,
  output logic             next_valid,
  output logic [CNT_W-1:0] count,
  output logic             pending
);

  localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]  SHAPE_NONE = 3'd7;

  typedef enum logic {
    FILL,
    READY
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [2:0]       last_shape;
  logic             reroll;

  logic [2:0]       mem_shape [DEPTH];
  logic [1:0]       mem_rot   [DEPTH];

  logic             is_repeat;
  logic             accept;
  logic             push;
  logic             pop;
  logic             full;
  logic [CNT_W-1:0] count_nxt;
  logic [PTR_W-1:0] rd_nxt;
  logic             pending_nxt;
  logic             reroll_nxt;
  logic [2:0]       last_nxt;
  logic [2:0]       head_nxt;

  // Next-state, filter, push/pop decisions and post-edge FIFO view
  always_comb begin
    state_d     = state_q;
    is_repeat   = 1'b0;
    accept      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    full        = (count == CNT_W'(DEPTH));
    count_nxt   = count;
    rd_nxt      = rd_ptr;
    pending_nxt = pending;
    reroll_nxt  = reroll;
    last_nxt    = last_shape;
    head_nxt    = 3'd0;

    is_repeat = (gen_shape == last_shape) && !reroll;
    accept    = (gen_shape != SHAPE_NONE) && !is_repeat;

    // Only READY may pop; an empty FIFO leaves the request pending
    pop  = (state_q == READY) && (spawn_req || pending) && (count != '0);
    push = accept && (!full || pop);

    // A request arriving while one is already pending is absorbed
    pending_nxt = pop ? 1'b0 : (pending || spawn_req);

    if (gen_shape != SHAPE_NONE) begin
      reroll_nxt = is_repeat;
    end
    // A piece lost to a full FIFO does not count as the last shape seen
    if (push) begin
      last_nxt = gen_shape;
    end

    if (push && !pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count - CNT_W'(1);
    end

    if (pop) begin
      rd_nxt = rd_ptr + PTR_W'(1);
    end

    // Head after this edge; a freshly pushed entry is not in memory yet
    if (count_nxt == '0) begin
      head_nxt = 3'd0;
    end else if (push && (rd_nxt == wr_ptr)) begin
      head_nxt = gen_shape;
    end else begin
      head_nxt = mem_shape[rd_nxt];
    end

    case (state_q)
      FILL: begin
        if (count_nxt == CNT_W'(DEPTH)) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State, pointers, filter history and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FILL;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      last_shape  <= SHAPE_NONE;
      reroll      <= 1'b0;
      count       <= '0;
      pending     <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_shape <= 3'd0;
      spawn_rot   <= 2'd0;
      next_shape  <= 3'd0;
      next_valid  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr      <= rd_nxt;
      wr_ptr      <= push ? (wr_ptr + PTR_W'(1)) : wr_ptr;
      last_shape  <= last_nxt;
      reroll      <= reroll_nxt;
      count       <= count_nxt;
      pending     <= pending_nxt;
      spawn_valid <= pop;
      if (pop) begin
        spawn_shape <= mem_shape[rd_ptr];
        spawn_rot   <= mem_rot[rd_ptr];
      end
      next_shape  <= head_nxt;
      next_valid  <= (count_nxt != '0);
    end
  end

  // FIFO storage, written at the tail on push
  always_ff @(posedge clk) begin
    if (push) begin
      mem_shape[wr_ptr] <= gen_shape;
      mem_rot[wr_ptr]   <= gen_rot;
    end
  end

endmodule

// File: tb/tb_piece_queue.sv
// Testbench for piece_queue: directed vectors, expected issues queued in a
// scoreboard and checked by a monitor whenever spawn_valid is presented.
module tb_piece_queue;

  typedef struct packed {
    logic [2:0] shape;
    logic [1:0] rot;
  } piece_t;

  logic       clk;
  logic       reset;
  logic [2:0] gen_shape;
  logic [1:0] gen_rot;
  logic       spawn_req;
  logic       spawn_valid;
  logic [2:0] spawn_shape;
  logic [1:0] spawn_rot;
  logic [2:0] next_shape;
  logic       next_valid;
  logic [2:0] count;
  logic       pending;

  piece_t exp_q[$];
  int     n_checks;
  int     n_fails;

  piece_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .gen_shape  (gen_shape),
    .gen_rot    (gen_rot),
    .spawn_req  (spawn_req),
    .spawn_valid(spawn_valid),
    .spawn_shape(spawn_shape),
    .spawn_rot  (spawn_rot),
    .next_shape (next_shape),
    .next_valid (next_valid),
    .count      (count),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; outputs are examined 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input logic [2:0] s, input logic [1:0] r);
    gen_shape = s;
    gen_rot   = r;
  endtask

  task automatic expect_issue(input logic [2:0] s, input logic [1:0] r);
    piece_t p;
    p.shape = s;
    p.rot   = r;
    exp_q.push_back(p);
  endtask

  task automatic check_q(input string name, input int c, input int ns, input int pend);
    check({name, ".count"}, int'(count), c);
    check({name, ".next_shape"}, int'(next_shape), ns);
    check({name, ".next_valid"}, int'(next_valid), int'(c != 0));
    check({name, ".pending"}, int'(pending), pend);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every issued piece must match the oldest expectation
  task automatic monitor();
    piece_t p;
    forever begin
      @(negedge clk);
      if (spawn_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_issue: got shape %0d rot %0d expected none",
                   spawn_shape, spawn_rot);
        end else begin
          p = exp_q.pop_front();
          if (spawn_shape != p.shape || spawn_rot != p.rot) begin
            n_fails++;
            $display("FAIL issue: got shape %0d rot %0d expected shape %0d rot %0d",
                     spawn_shape, spawn_rot, p.shape, p.rot);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fails   = 0;
    reset     = 1'b0;
    spawn_req = 1'b0;
    gen(3'd7, 2'd0);
    fork
      monitor();
    join_none

    // Reset state
    do_reset();
    check_q("reset", 0, 0, 0);
    check("reset.spawn_valid", int'(spawn_valid), 0);
    check("reset.spawn_shape", int'(spawn_shape), 0);
    check("reset.spawn_rot", int'(spawn_rot), 0);

    // T1 fill
    gen(3'd1, 2'd1); step(); check_q("t1.a", 1, 1, 0);
    gen(3'd2, 2'd2); step(); check_q("t1.b", 2, 1, 0);
    gen(3'd3, 2'd3); step(); check_q("t1.c", 3, 1, 0);
    gen(3'd4, 2'd0); step(); check_q("t1.d", 4, 1, 0);
    gen(3'd7, 2'd0); step(); check_q("t1.hold", 4, 1, 0);

    // T3 spawn from full queue
    spawn_req = 1'b1;
    expect_issue(3'd1, 2'd1);
    step();
    spawn_req = 1'b0;
    check("t3.spawn_valid", int'(spawn_valid), 1);
    check_q("t3", 3, 2, 0);
    step();
    check("t3.pulse_end", int'(spawn_valid), 0);
    check("t3.shape_held", int'(spawn_shape), 1);

    // T4 simultaneous push and pop on a full queue
    gen(3'd5, 2'd1); step(); check_q("t4.refill", 4, 2, 0);
    gen(3'd6, 2'd2);
    spawn_req = 1'b1;
    expect_issue(3'd2, 2'd2);
    step();
    spawn_req = 1'b0;
    gen(3'd7, 2'd0);
    check_q("t4", 4, 3, 0);

    // T5 drain; the tail must be the 6 pushed above
    spawn_req = 1'b1;
    expect_issue(3'd3, 2'd3); step(); check_q("t5.d1", 3, 4, 0);
    expect_issue(3'd4, 2'd0); step(); check_q("t5.d2", 2, 5, 0);
    expect_issue(3'd5, 2'd1); step(); check_q("t5.d3", 1, 6, 0);
    expect_issue(3'd6, 2'd2); step(); check_q("t5.d4", 0, 0, 0);
    step();
    check_q("t5.empty_req", 0, 0, 1);
    spawn_req = 1'b0;
    step();
    check_q("t5.pending", 0, 0, 1);
    check("t5.no_issue", int'(spawn_valid), 0);
    gen(3'd2, 2'd1);
    expect_issue(3'd2, 2'd1);
    step();
    check_q("t5.push", 1, 2, 1);
    gen(3'd7, 2'd0);
    step();
    check_q("t5.served", 0, 0, 0);
    check("t5.spawn_valid", int'(spawn_valid), 1);
    step();
    check("t5.pulse_end", int'(spawn_valid), 0);

    // Second request while pending is not queued
    spawn_req = 1'b1;
    step(); check_q("req.first", 0, 0, 1);
    step(); check_q("req.second", 0, 0, 1);
    spawn_req = 1'b0;
    gen(3'd3, 2'd0); expect_issue(3'd3, 2'd0); step(); check_q("req.push", 1, 3, 1);
    gen(3'd4, 2'd2); step(); check_q("req.pop_push", 1, 4, 0);
    gen(3'd7, 2'd0); step(); check_q("req.no_second", 1, 4, 0);

    // T6 reset mid-operation (pending with entries only exists in FILL)
    do_reset();
    spawn_req = 1'b1;
    gen(3'd1, 2'd0); step(); check_q("t6.fill_req", 1, 1, 1);
    spawn_req = 1'b0;
    gen(3'd2, 2'd0); step(); check_q("t6.pre", 2, 1, 1);
    gen(3'd7, 2'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_q("t6.post", 0, 0, 0);
    check("t6.spawn_valid", int'(spawn_valid), 0);
    spawn_req = 1'b1;
    gen(3'd5, 2'd0); step();
    spawn_req = 1'b0;
    gen(3'd7, 2'd0); step(); check_q("t6.fill_state", 1, 5, 1);

    // T2 filter: 7 dropped, first repeat dropped, second repeat accepted
    do_reset();
    gen(3'd7, 2'd0); step(); check_q("t2.seven", 0, 0, 0);
    gen(3'd5, 2'd1); step(); check_q("t2.a", 1, 5, 0);
    gen(3'd5, 2'd2); step(); check_q("t2.rep_drop", 1, 5, 0);
    gen(3'd5, 2'd3); step(); check_q("t2.rep_take", 2, 5, 0);
    gen(3'd6, 2'd0); step(); check_q("t2.b", 3, 5, 0);
    gen(3'd6, 2'd1); step(); check_q("t2.rep_drop2", 3, 5, 0);
    gen(3'd6, 2'd2); step(); check_q("t2.full", 4, 5, 0);
    // Lost at full: last shape stays 6, so the next 3 is accepted
    gen(3'd3, 2'd1); step(); check_q("t2.lost", 4, 5, 0);
    gen(3'd3, 2'd2);
    spawn_req = 1'b1;
    expect_issue(3'd5, 2'd1); step(); check_q("t2.swap", 4, 5, 0);
    gen(3'd7, 2'd0);
    expect_issue(3'd5, 2'd3); step(); check_q("t2.d1", 3, 6, 0);
    expect_issue(3'd6, 2'd0); step(); check_q("t2.d2", 2, 6, 0);
    expect_issue(3'd6, 2'd2); step(); check_q("t2.d3", 1, 3, 0);
    expect_issue(3'd3, 2'd2); step(); check_q("t2.d4", 0, 0, 0);
    spawn_req = 1'b0;

    // Bounded wait for outstanding issues
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      step();
    end
    step();
    check("scoreboard.outstanding", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
